// File: rtl/seg7_monitor_if.sv
// seg7_monitor_if: ready/valid output stream carrying decoded display bytes
//   value : decoded byte {hex(disp1), hex(disp0)} at the FIFO head
//   valid : value is meaningful (FIFO non-empty)
//   ready : consumer accepts value; an entry pops when valid && ready
interface seg7_monitor_if;
   logic [7:0] value;
   logic       valid;
   logic       ready;
   modport master (output value, valid, input ready);
   modport slave  (input value, valid, output ready);
endinterface

// File: rtl/seg7_monitor.sv
// seg7_monitor: debounces a two-digit 7-segment display, decodes stable pairs into a FWFT FIFO
//   clock     : sole clock, rising edge
//   n_reset   : asynchronous active-low reset
//   disp0     : low-digit segments {g,f,e,d,c,b,a}, active-low
//   disp1     : high-digit segments, same encoding
//   out       : master stream of decoded bytes (value/valid/ready)
//   illegal   : one-cycle pulse after an accepted pair containing an undecodable digit
//   err_count : number of illegal accepts, saturating at 255
//   overflow  : sticky, set when a legal accepted pair is dropped on a full FIFO
module seg7_monitor #(
   parameter int STABLE_CYCLES = 4,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                 clock,
   input  logic                 n_reset,
   input  logic [6:0]           disp0,
   input  logic [6:0]           disp1,
   seg7_monitor_if.master       out,
   output logic                 illegal,
   output logic [7:0]           err_count,
   output logic                 overflow
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [3:0]  STABLE = 4'(STABLE_CYCLES);
   localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
   // {legal, blank, hex}
   function automatic logic [5:0] seg_decode(input logic [6:0] seg);
      case (seg)
         7'h40: seg_decode = 6'h20;
         7'h79: seg_decode = 6'h21;
         7'h24: seg_decode = 6'h22;
         7'h30: seg_decode = 6'h23;
         7'h19: seg_decode = 6'h24;
         7'h12: seg_decode = 6'h25;
         7'h02: seg_decode = 6'h26;
         7'h78: seg_decode = 6'h27;
         7'h00: seg_decode = 6'h28;
         7'h10: seg_decode = 6'h29;
         7'h08: seg_decode = 6'h2A;
         7'h03: seg_decode = 6'h2B;
         7'h46: seg_decode = 6'h2C;
         7'h21: seg_decode = 6'h2D;
         7'h06: seg_decode = 6'h2E;
         7'h0E: seg_decode = 6'h2F;
         7'h7F: seg_decode = 6'h10;
         default: seg_decode = 6'h00;
      endcase
   endfunction
   logic [13:0]   cand_q, cand_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          illegal_q, illegal_d;
   logic [7:0]    err_q, err_d;
   logic          overflow_q, overflow_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [7:0]    mem_d [FIFO_DEPTH];
   logic [5:0]    dec1, dec0;
   logic          same, accept, push, bad, pop, full, wr;
   always_comb begin
      same       = {disp1, disp0} == cand_q;
      dec1       = seg_decode(cand_q[13:7]);
      dec0       = seg_decode(cand_q[6:0]);
      cand_d     = same ? cand_q : {disp1, disp0};
      cnt_d      = !same ? 4'd1 : (cnt_q < STABLE ? cnt_q + 4'd1 : cnt_q);
      // the edge that brings cnt up to STABLE is the single accept edge for this pattern
      accept     = same && cnt_q == STABLE - 4'd1;
      push       = accept && dec1[5] && dec0[5];
      bad        = accept && !(dec1[5] && dec0[5]) && !(dec1[4] && dec0[4]);
      illegal_d  = bad;
      err_d      = (bad && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
      pop        = out.valid && out.ready;
      full       = count_q == FULL;
      wr         = push && (!full || pop);
      overflow_d = overflow_q | (push && full && !pop);
      count_d    = count_q + CW'(wr) - CW'(pop);
      wr_ptr_d   = wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      mem_d      = mem_q;
      // on full push+pop wr_ptr equals rd_ptr: the head is read this cycle and freed at the edge
      if (wr) mem_d[wr_ptr_q] = {dec1[3:0], dec0[3:0]};
   end
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         cand_q     <= 14'h3FFF;
         cnt_q      <= STABLE;
         illegal_q  <= 1'b0;
         err_q      <= 8'h00;
         overflow_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
      end else begin
         cand_q     <= cand_d;
         cnt_q      <= cnt_d;
         illegal_q  <= illegal_d;
         err_q      <= err_d;
         overflow_q <= overflow_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         mem_q      <= mem_d;
      end
   end
   assign out.valid = count_q != '0;
   assign out.value = out.valid ? mem_q[rd_ptr_q] : 8'h00;
   assign illegal   = illegal_q;
   assign err_count = err_q;
   assign overflow  = overflow_q;
endmodule

// File: tb/tb_seg7_monitor.sv
// tb_seg7_monitor: directed self-checking bench for seg7_monitor
module tb_seg7_monitor;
   logic       clock = 1'b0;
   logic       n_reset = 1'b0;
   logic [6:0] disp0 = 7'h7F;
   logic [6:0] disp1 = 7'h7F;
   logic       illegal, overflow;
   logic [7:0] err_count;
   logic       mon_en = 1'b0;
   logic       seen = 1'b0;
   int         checks = 0;
   int         errors = 0;
   seg7_monitor_if bus ();
   seg7_monitor #(.STABLE_CYCLES(4), .FIFO_DEPTH(4)) dut (
      .clock(clock), .n_reset(n_reset), .disp0(disp0), .disp1(disp1),
      .out(bus), .illegal(illegal), .err_count(err_count), .overflow(overflow)
   );
   always #5 clock = ~clock;
   always @(negedge clock) if (mon_en && (illegal || bus.valid)) seen <= 1'b1;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic hold(input logic [6:0] d1, input logic [6:0] d0, input int n);
      disp1 = d1;
      disp0 = d0;
      repeat (n) @(negedge clock);
   endtask
   task automatic drain(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d);
      logic [7:0] exp [4];
      exp = '{a, b, c, d};
      bus.ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check({tag, "_valid"}, bus.valid, 1);
         check({tag, "_value"}, bus.value, exp[i]);
         @(negedge clock);
      end
      check({tag, "_empty"}, bus.valid, 0);
      bus.ready = 1'b0;
   endtask
   initial begin
      bus.ready = 1'b0;
      // reset state
      repeat (2) @(negedge clock);
      check("rst_valid", bus.valid, 0);
      check("rst_value", bus.value, 8'h00);
      check("rst_illegal", illegal, 0);
      check("rst_err", err_count, 0);
      check("rst_ovf", overflow, 0);
      n_reset = 1'b1;
      mon_en = 1'b1;
      repeat (20) @(negedge clock);
      mon_en = 1'b0;
      check("blank_no_activity", seen, 0);
      check("blank_err", err_count, 0);
      check("blank_ovf", overflow, 0);
      // decode 24/19 -> 0x24
      bus.ready = 1'b1;
      hold(7'h24, 7'h19, 3);
      check("dec_not_yet", bus.valid, 0);
      @(negedge clock);
      check("dec_valid", bus.valid, 1);
      check("dec_value", bus.value, 8'h24);
      @(negedge clock);
      check("dec_popped", bus.valid, 0);
      repeat (4) @(negedge clock);
      check("dec_once", bus.valid, 0);
      // glitch: 30/12 for 3 edges never accepted, 79/40 -> 0x10
      bus.ready = 1'b0;
      hold(7'h30, 7'h12, 3);
      check("glitch_none", bus.valid, 0);
      hold(7'h79, 7'h40, 3);
      check("glitch_not_yet", bus.valid, 0);
      @(negedge clock);
      check("glitch_valid", bus.valid, 1);
      check("glitch_value", bus.value, 8'h10);
      bus.ready = 1'b1;
      @(negedge clock);
      check("glitch_one_entry", bus.valid, 0);
      bus.ready = 1'b0;
      // illegal digit 55, then single blank
      hold(7'h40, 7'h55, 3);
      check("ill_pre", illegal, 0);
      @(negedge clock);
      check("ill_pulse", illegal, 1);
      check("ill_err1", err_count, 1);
      check("ill_nopush", bus.valid, 0);
      @(negedge clock);
      check("ill_one_cycle", illegal, 0);
      hold(7'h40, 7'h7F, 4);
      check("half_blank_pulse", illegal, 1);
      check("half_blank_err2", err_count, 2);
      check("half_blank_nopush", bus.valid, 0);
      hold(7'h7F, 7'h7F, 4);
      check("clear_no_pulse", illegal, 0);
      check("clear_err", err_count, 2);
      check("clear_nopush", bus.valid, 0);
      // overflow: five pairs into a depth-4 FIFO
      hold(7'h40, 7'h40, 4);
      hold(7'h40, 7'h79, 4);
      hold(7'h40, 7'h24, 4);
      hold(7'h40, 7'h30, 4);
      check("ovf_before", overflow, 0);
      hold(7'h40, 7'h19, 4);
      check("ovf_set", overflow, 1);
      drain("ovf_pop", 8'h00, 8'h01, 8'h02, 8'h03);
      check("ovf_sticky", overflow, 1);
      // asynchronous reset with an entry queued and a pattern mid-count
      hold(7'h40, 7'h40, 4);
      check("ar_queued", bus.valid, 1);
      hold(7'h40, 7'h79, 2);
      #2 n_reset = 1'b0;
      #1;
      check("ar_valid", bus.valid, 0);
      check("ar_value", bus.value, 8'h00);
      check("ar_err", err_count, 0);
      check("ar_ovf", overflow, 0);
      disp1 = 7'h7F;
      disp0 = 7'h7F;
      @(negedge clock);
      n_reset = 1'b1;
      repeat (10) @(negedge clock);
      check("ar_blank_idle", bus.valid, 0);
      hold(7'h40, 7'h79, 3);
      check("ar_recount", bus.valid, 0);
      @(negedge clock);
      check("ar_accept", bus.value, 8'h01);
      bus.ready = 1'b1;
      @(negedge clock);
      check("ar_pop", bus.valid, 0);
      bus.ready = 1'b0;
      // full FIFO, push of 0F coincides with a pop
      hold(7'h40, 7'h40, 4);
      hold(7'h40, 7'h79, 4);
      hold(7'h40, 7'h24, 4);
      hold(7'h40, 7'h30, 4);
      hold(7'h40, 7'h0E, 3);
      bus.ready = 1'b1;
      @(negedge clock);
      check("fpp_ovf", overflow, 0);
      drain("fpp_pop", 8'h01, 8'h02, 8'h03, 8'h0F);
      check("fpp_ovf_end", overflow, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/seg7_monitor.md
SEG7_MONITOR -- requirements
Module: seg7_monitor

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, number of consecutive identical samples needed to accept a display pattern; legal range 2..15.
REQ-002 Parameter FIFO_DEPTH, default 4, capacity in entries of the output FIFO; power of 2.
REQ-003 clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 n_reset  input  1  asynchronous, active-low reset.
REQ-005 disp0  input  7  low-digit segments {g,f,e,d,c,b,a}, active-low.
REQ-006 disp1  input  7  high-digit segments, same encoding as disp0.
REQ-007 value  output  8  FIFO head, {hex(disp1), hex(disp0)}.
REQ-008 valid  output  1  FIFO non-empty; value is meaningful.
REQ-009 ready  input  1  consumer accepts value; pop on valid && ready.
REQ-010 illegal  output  1  one-cycle pulse when an accepted pair contains an undecodable digit.
REQ-011 err_count  output  8  count of illegal accepts, saturating at 255.
REQ-012 overflow  output  1  sticky; set when an accepted legal pair is dropped because the FIFO is full.

Function
REQ-013 The legal digit table (hex -> pattern, 7-bit hex) SHALL be: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 B=03 C=46 D=21 E=06 F=0E; blank=7F; every other pattern is illegal.
REQ-014 Registers: cand (14 bits, last seen {disp1,disp0}) and cnt (4 bits, saturating at STABLE_CYCLES).
REQ-015 Each edge with {disp1,disp0} != cand: cand <= input, cnt <= 1, no accept.
REQ-016 Each edge with input == cand and cnt < STABLE_CYCLES: cnt increments; the edge on which cnt becomes STABLE_CYCLES is the accept edge.
REQ-017 Input == cand with cnt == STABLE_CYCLES: no change; each stable pattern is accepted exactly once.
REQ-018 Latency: a pair first present before edge k and held is accepted at edge k+STABLE_CYCLES-1; valid is high after that edge if the FIFO was empty.
REQ-019 Accept of two legal digits: push decoded byte at the accept edge; if full and no pop that edge, drop and set overflow.
REQ-020 Accept of both digits blank: no push, no error (display cleared).
REQ-021 Accept with any digit illegal, or exactly one digit blank: no push, illegal=1 for the following cycle only, err_count +1 unless 255.
REQ-022 FIFO is first-word-fall-through: value = oldest entry, valid = (occupancy != 0); value is don't-care when valid=0.
REQ-023 Push and pop on the same edge when full: both occur, occupancy unchanged, overflow unchanged.
REQ-024 Push and pop on the same edge when empty: not possible (valid=0), push only.
REQ-025 Pointers wrap modulo FIFO_DEPTH; occupancy tracked with FIFO_DEPTH+1 states to distinguish full from empty.
REQ-026 ready is ignored when valid=0.

Reset
REQ-027 n_reset low SHALL immediately, independent of clock: cand=7F7F, cnt=STABLE_CYCLES, FIFO empty, valid=0, illegal=0, err_count=0, overflow=0, value=00.
REQ-028 Reset asserted mid-count or with FIFO entries discards all pending state; no accept occurs for the pattern in progress.
REQ-029 After release with input blank/blank, no accept occurs (pattern already treated as accepted).

Verification
REQ-030 Reset: disp0=disp1=7F, n_reset pulse, 20 cycles -> valid=0, illegal never high, err_count=0, overflow=0.
REQ-031 Decode: disp1=24, disp0=19 held from edge 0, ready=1 -> valid rises after edge 3, value=24 for one cycle, one entry only.
REQ-032 Glitch: pair 30/12 held 3 edges then changed to 79/40 held 4 -> only value=10 delivered; 35 never appears.
REQ-033 Illegal: disp1=40, disp0=55 held 4 edges -> illegal pulses one cycle after edge 3, err_count=1, no push; then 40/7F -> err_count=2.
REQ-034 Overflow: ready=0, five distinct legal pairs 00..04 each held 4 edges -> 4 entries 00,01,02,03, overflow=1; then ready=1 pops in that order.
REQ-035 Full push+pop: FIFO full, ready=1 on the edge a new legal pair 0F is accepted -> occupancy stays 4, overflow stays 0, 0F is last out.
